// File: rtl/mem_responder_if.sv
// Memory handshake between the control unit (master) and the memory responder (slave).
// Request fields are qualified by MOV and are held by the master until MOC is seen.
interface mem_responder_if;
  logic        MOV;
  logic        R_W;
  logic [1:0]  DT;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MOC;
  logic        ERR;

  modport master (
    output MOV, R_W, DT, Address, DataIn,
    input  DataOut, MOC, ERR
  );

  modport slave (
    input  MOV, R_W, DT, Address, DataIn,
    output DataOut, MOC, ERR
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: latches a MOV request, waits WAIT_STATES cycles, then performs a
// big-endian byte/halfword/word access to an internal byte RAM and raises MOC until MOV drops.
module mem_responder #(
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             clr,
  mem_responder_if.slave   bus,
  output logic [1:0]       dbg_state
);

  localparam int MEM_BYTES = 2 ** ADDR_BITS;

  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  // Handshake: a request is accepted on an IDLE edge sampling MOV=1; MOC rises after the
  // wait states and stays high until an edge samples MOV=0, which returns to IDLE.
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [1:0]  dt_q, dt_d;
  addr_t       addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] dout_q, dout_d;
  logic        moc_q, moc_d;
  logic        err_q, err_d;

  logic [7:0]  mem [MEM_BYTES];

  addr_t       a0, a1, a2, a3;
  logic        misaligned;
  logic        reserved;
  logic        mem_we;
  logic [31:0] rdata;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^bus.Address[31:ADDR_BITS];

  // Force the alignment bits low; consecutive byte indices wrap with the address width.
  always_comb begin
    a0         = addr_q;
    misaligned = 1'b0;
    case (dt_q)
      2'b01: begin
        a0         = {addr_q[ADDR_BITS-1:1], 1'b0};
        misaligned = addr_q[0];
      end
      2'b10: begin
        a0         = {addr_q[ADDR_BITS-1:2], 2'b00};
        misaligned = |addr_q[1:0];
      end
      default: ;
    endcase
    a1 = a0 + addr_t'(1);
    a2 = a0 + addr_t'(2);
    a3 = a0 + addr_t'(3);
  end

  assign reserved = (dt_q == 2'b11);

  always_comb begin
    case (dt_q)
      2'b00:   rdata = {24'b0, mem[a0]};
      2'b01:   rdata = {16'b0, mem[a0], mem[a1]};
      default: rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    dt_d    = dt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    moc_d   = moc_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.MOV) begin
          rw_d    = bus.R_W;
          dt_d    = bus.DT;
          addr_d  = bus.Address[ADDR_BITS-1:0];
          wdata_d = bus.DataIn;
          cnt_d   = 4'(WAIT_STATES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          moc_d   = 1'b1;
          err_d   = misaligned | reserved;
          mem_we  = !rw_q && !reserved;
          if (rw_q && !reserved) dout_d = rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.MOV) begin
          moc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      dt_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      dout_q  <= 32'd0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      dt_q    <= dt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
    end
  end

  // RAM has no reset; mem_we is only possible from BUSY, so a reset abandons uncommitted writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      case (dt_q)
        2'b00: mem[a0] <= wdata_q[7:0];
        2'b01: begin
          mem[a0] <= wdata_q[15:8];
          mem[a1] <= wdata_q[7:0];
        end
        default: begin
          mem[a0] <= wdata_q[31:24];
          mem[a1] <= wdata_q[23:16];
          mem[a2] <= wdata_q[15:8];
          mem[a3] <= wdata_q[7:0];
        end
      endcase
    end
  end

  assign bus.DataOut = dout_q;
  assign bus.MOC     = moc_q;
  assign bus.ERR     = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized requests
// checked against a byte-array reference model of the RAM and the read-data register.
module tb_mem_responder;
  localparam int ADDR_BITS   = 9;
  localparam int WAIT_STATES = 2;
  localparam int MEM_BYTES   = 2 ** ADDR_BITS;
  localparam int EXP_LAT     = WAIT_STATES + 1;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] dbg_state;

  mem_responder_if bus ();

  mem_responder #(.ADDR_BITS(ADDR_BITS), .WAIT_STATES(WAIT_STATES)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [7:0]  model_mem [MEM_BYTES];
  logic [31:0] model_dout = 32'd0;

  // Reference: returns the expected ERR and updates model_mem / model_dout.
  function automatic logic model_access(input logic rw, input logic [1:0] dt,
                                        input logic [31:0] addr, input logic [31:0] wd);
    int n, a;
    logic [31:0] r;
    if (dt == 2'b11) return 1'b1;
    n = 1 << dt;
    a = int'(addr % MEM_BYTES);
    a = a - (a % n);
    if (rw) begin
      r = 32'd0;
      for (int i = 0; i < n; i++) r = (r << 8) | 32'(model_mem[(a + i) % MEM_BYTES]);
      model_dout = r;
    end else begin
      for (int i = 0; i < n; i++) model_mem[(a + i) % MEM_BYTES] = 8'(wd >> (8 * (n - 1 - i)));
    end
    return (addr % n) != 0;
  endfunction

  task automatic do_req(input logic rw, input logic [1:0] dt, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold, input bit drop_early,
                        input bit quick, output int lat, output logic [31:0] dout,
                        output logic err, output bit stable, output logic moc_after);
    bit got;
    if (!quick) @(negedge clk);
    bus.MOV = 1'b1; bus.R_W = rw; bus.DT = dt; bus.Address = addr; bus.DataIn = wd;
    @(posedge clk);
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (lat == 1) begin
        bus.R_W = 1'($urandom); bus.DT = 2'($urandom);
        bus.Address = $urandom; bus.DataIn = $urandom;
        if (drop_early) bus.MOV = 1'b0;
      end
      if (bus.MOC === 1'b1) got = 1;
    end
    if (!got) lat = -1;
    dout = bus.DataOut; err = bus.ERR; stable = 1;
    repeat (hold) begin
      @(negedge clk);
      if (bus.MOC !== 1'b1 || bus.DataOut !== dout) stable = 0;
    end
    bus.MOV = 1'b0;
    @(posedge clk); #1;
    moc_after = bus.MOC;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (bus.MOC !== 1'b0) begin n_fail++; $display("FAIL rst_moc: got %b want 0", bus.MOC); end
    n_cmp++; if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.ERR); end
    n_cmp++; if (bus.DataOut !== 32'd0) begin n_fail++; $display("FAIL rst_dout: got %h want 0", bus.DataOut); end
    repeat (2) @(negedge clk);
    clr = 1'b1;
  endtask

  // One request with every observable checked against the model.
  task automatic checked_req(input string nm, input logic rw, input logic [1:0] dt,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int hold, input bit drop_early, input bit quick);
    int lat; logic [31:0] dout; logic err, moc_after, exp_err; bit stable; int a4;
    do_req(rw, dt, addr, wd, hold, drop_early, quick, lat, dout, err, stable, moc_after);
    exp_err = model_access(rw, dt, addr, wd);
    n_cmp++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL %s lat: got %0d want %0d", nm, lat, EXP_LAT); end
    n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL %s err: got %b want %b", nm, err, exp_err); end
    n_cmp++; if (dout !== model_dout) begin n_fail++; $display("FAIL %s dout: got %h want %h", nm, dout, model_dout); end
    n_cmp++; if (!stable) begin n_fail++; $display("FAIL %s stable: got 0 want 1", nm); end
    n_cmp++; if (moc_after !== 1'b0) begin n_fail++; $display("FAIL %s moc_fall: got %b want 0", nm, moc_after); end
    a4 = int'(addr % MEM_BYTES) & ~3;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dut.mem[a4 + i] !== model_mem[a4 + i]) begin
        n_fail++;
        $display("FAIL %s mem[%h]: got %h want %h", nm, a4 + i, dut.mem[a4 + i], model_mem[a4 + i]);
      end
    end
  endtask

  task automatic test_word();
    checked_req("wr_word10", 1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    n_cmp++; if (dut.mem[16'h10] !== 8'hDE || dut.mem[16'h13] !== 8'hEF) begin
      n_fail++; $display("FAIL wr_word10_bytes: got %h..%h want de..ef", dut.mem[16'h10], dut.mem[16'h13]);
    end
    checked_req("rd_word10", 1'b1, 2'b10, 32'h10, 32'h0, 0, 0, 0);
    n_cmp++; if (bus.DataOut !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_word10_abs: got %h want deadbeef", bus.DataOut); end
  endtask

  task automatic test_byte_half();
    checked_req("rd_byte12", 1'b1, 2'b00, 32'h12, 32'h0, 1, 0, 0);
    checked_req("wr_half12", 1'b0, 2'b01, 32'h12, 32'h1234, 0, 0, 0);
    checked_req("rd_word10b", 1'b1, 2'b10, 32'h10, 32'h0, 0, 0, 0);
    n_cmp++; if (bus.DataOut !== 32'hDEAD1234) begin n_fail++; $display("FAIL rd_word10b_abs: got %h want dead1234", bus.DataOut); end
  endtask

  task automatic test_err_cases();
    checked_req("rd_mis13", 1'b1, 2'b10, 32'h13, 32'h0, 0, 0, 0);
    checked_req("wr_dt11", 1'b0, 2'b11, 32'h10, 32'hFFFFFFFF, 0, 0, 0);
    checked_req("rd_dt11", 1'b1, 2'b11, 32'h40, 32'h0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    checked_req("wr_word1ff", 1'b0, 2'b10, 32'h1FF, 32'hCAFEF00D, 0, 0, 0);
    checked_req("wr_byte200", 1'b0, 2'b00, 32'h200, 32'hAA, 0, 0, 0);
    n_cmp++; if (dut.mem[0] !== 8'hAA) begin n_fail++; $display("FAIL wrap_byte0: got %h want aa", dut.mem[0]); end
  endtask

  task automatic test_handshake();
    checked_req("hold10", 1'b1, 2'b10, 32'h10, 32'h0, 10, 0, 0);
    checked_req("drop_busy", 1'b0, 2'b01, 32'h50, 32'hBEEF, 0, 1, 0);
    checked_req("reraise_a", 1'b1, 2'b01, 32'h50, 32'h0, 0, 0, 0);
    checked_req("reraise_b", 1'b1, 2'b00, 32'h51, 32'h0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    // Reset while in DONE: committed write stays, MOC drops without a clock edge.
    @(negedge clk);
    bus.MOV = 1'b1; bus.R_W = 1'b0; bus.DT = 2'b00; bus.Address = 32'h30; bus.DataIn = 32'h77;
    repeat (EXP_LAT + 1) @(posedge clk);
    #3;
    n_cmp++; if (bus.MOC !== 1'b1) begin n_fail++; $display("FAIL done_moc: got %b want 1", bus.MOC); end
    void'(model_access(1'b0, 2'b00, 32'h30, 32'h77));
    clr = 1'b0; #1;
    n_cmp++; if (bus.MOC !== 1'b0) begin n_fail++; $display("FAIL rst_done_moc: got %b want 0", bus.MOC); end
    n_cmp++; if (dut.mem[16'h30] !== model_mem[16'h30]) begin n_fail++; $display("FAIL rst_done_mem: got %h want %h", dut.mem[16'h30], model_mem[16'h30]); end
    bus.MOV = 1'b0;
    @(negedge clk); clr = 1'b1;
    // Reset while in BUSY: the byte write of 0x55 must never reach the RAM.
    checked_req("rd_prep", 1'b1, 2'b10, 32'h10, 32'h0, 0, 0, 0);
    @(negedge clk);
    bus.MOV = 1'b1; bus.R_W = 1'b0; bus.DT = 2'b00; bus.Address = 32'h20; bus.DataIn = 32'h55;
    @(posedge clk); #3;
    clr = 1'b0; #1;
    model_dout = 32'd0;
    n_cmp++; if (bus.MOC !== 1'b0) begin n_fail++; $display("FAIL rst_busy_moc: got %b want 0", bus.MOC); end
    n_cmp++; if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL rst_busy_err: got %b want 0", bus.ERR); end
    n_cmp++; if (bus.DataOut !== 32'd0) begin n_fail++; $display("FAIL rst_busy_dout: got %h want 0", bus.DataOut); end
    bus.MOV = 1'b0;
    repeat (4) @(posedge clk);
    n_cmp++; if (dut.mem[16'h20] !== 8'h11) begin n_fail++; $display("FAIL rst_busy_mem: got %h want 11", dut.mem[16'h20]); end
    @(negedge clk); clr = 1'b1;
    checked_req("after_rst", 1'b1, 2'b00, 32'h20, 32'h0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [1:0] dt; int hold; bit drop;
    for (int i = 0; i < 80; i++) begin
      dt   = 2'($urandom_range(0, 3));
      drop = ($urandom_range(0, 7) == 0);
      hold = drop ? 0 : $urandom_range(0, 3);
      checked_req("rand", 1'($urandom), dt, $urandom, $urandom, hold, drop, 0);
    end
  endtask

  initial begin
    bus.MOV = 1'b0; bus.R_W = 1'b0; bus.DT = 2'b00; bus.Address = 32'd0; bus.DataIn = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (i == 16'h20) b = 8'h11;
      dut.mem[i]   = b;
      model_mem[i] = b;
    end
    test_reset();
    test_word();
    test_byte_half();
    test_err_cases();
    test_wrap();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the control unit's memory handshake. It accepts a MOV request with the address latched from MAR, direction on R_W, size on DT and write data from MDR, then performs a byte-addressed, big-endian access to an internal RAM. Completion is signalled on MOC after a programmable number of wait states. It is the counterpart the control unit waits on in its fetch, load and store states.

## Interface

Parameters:
- ADDR_BITS, 9: RAM is 2**ADDR_BITS bytes; higher address bits are ignored, so addresses wrap modulo the RAM size.
- WAIT_STATES, 2: extra cycles between accepting a request and asserting MOC (0..15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-low reset (0 = reset).
- MOV  in  1  memory operation valid; held high by the control unit until MOC is seen.
- R_W  in  1  1 = read, 0 = write; sampled with MOV.
- DT  in  2  data type: 00 byte, 01 halfword, 10 word, 11 reserved.
- Address  in  32  byte address from MAR.
- DataIn  in  32  write data from MDR; right-justified for byte and halfword writes.
- DataOut  out  32  read data to MDR.
- MOC  out  1  memory operation complete.
- ERR  out  1  reserved DT or misaligned access on the current completion.

## Operation

- States: IDLE, BUSY, DONE.
- IDLE:
  - MOV=1 at an edge latches R_W, DT, Address[ADDR_BITS-1:0] and DataIn, loads wait counter = WAIT_STATES, and moves to BUSY.
  - MOV=0 keeps the block in IDLE.
- BUSY:
  - Counter > 0: decrement.
  - Counter = 0: perform the access, drive the result, set MOC=1, and move to DONE.
  - MOV dropping during BUSY is ignored. The latched request completes.
- DONE:
  - MOC stays 1 while MOV=1.
  - MOV=0 at an edge clears MOC and ERR and returns to IDLE.
  - A new request needs MOV low for at least one edge; no back-to-back acceptance from DONE.
- Access rules. Let a = latched address with the low alignment bits forced to 0 (bit0 for halfword, bits1:0 for word).
  - Byte read: DataOut = {24'b0, mem[a]}.
  - Byte write: mem[a] = DataIn[7:0].
  - Halfword read: DataOut = {16'b0, mem[a], mem[a+1]}.
  - Halfword write: mem[a] = DataIn[15:8], mem[a+1] = DataIn[7:0].
  - Word, big-endian: mem[a] = bits 31:24 through mem[a+3] = bits 7:0.
  - Byte-index arithmetic wraps modulo 2**ADDR_BITS.
- Misaligned halfword or word: the access is performed at the aligned address, and ERR=1 with MOC.
- DT=11: no memory change; DataOut unchanged; MOC and ERR asserted normally.
- DataOut changes only on a read completion and holds until the next read completion. Writes leave it unchanged.
- Memory contents are not affected by reset. The bench initializes them by backdoor.

## Timing

- Reset (clr=0, asynchronous): state IDLE, MOC=0, ERR=0, DataOut=0, counter=0. This takes effect immediately, with no clock needed.
- Reset mid-operation: the request is abandoned. A write not yet committed (still in BUSY) must not modify memory. A write already committed stays.
- Latency: MOV sampled high at edge k gives MOC=1 after edge k+1+WAIT_STATES. With WAIT_STATES=0, MOC is high one cycle after acceptance.
- The write commits at the same edge MOC rises.
- DataOut is valid no later than MOC rising and is stable for the whole DONE period.
- MOC falls at the first edge that samples MOV=0 in DONE.
- Minimum request-to-request period: WAIT_STATES + 3 edges.
- Inputs other than MOV are sampled only at the accepting edge. Changes during BUSY and DONE have no effect.

## Test plan

1. Reset, then write word 0xDEADBEEF at 0x10 (WAIT_STATES=2). Required:
   - MOC rises 3 edges after acceptance.
   - mem[0x10..0x13] = DE, AD, BE, EF.
   - Word read of 0x10 returns DataOut = 0xDEADBEEF.
2. Byte read at 0x12 returns 0x000000BE. Halfword write of 0x1234 at 0x12, then word read of 0x10, returns 0xDEAD1234.
3. Misaligned word read at 0x13 returns 0xDEAD1234 with ERR=1. DT=11 write of 0xFFFFFFFF at 0x10 leaves memory unchanged, with ERR=1 and MOC=1.
4. Address 0x000001FF word write with ADDR_BITS=9 (aligned down to 0x1FC). Separately, byte write of 0xAA at 0x200 lands at mem[0x000] (wrap).
5. Handshake:
   - MOV held high 10 cycles after MOC keeps MOC=1 with DataOut stable.
   - MOV dropped during BUSY still completes the access.
   - MOV re-raised in the same cycle MOC falls is not accepted until MOV has been sampled low.
6. Reset mid-operation:
   - clr pulsed low during BUSY of a write of 0x55 to 0x20: MOC and ERR clear immediately, and mem[0x20] is unchanged.
   - The next request after clr rises completes normally.
